// File: rtl/spi_byte_engine.sv
// -----------------------------------------------------------------------------
// spi_byte_engine
//   Mode-0 SPI master that shifts one byte for each rising edge of the
//   software "go" bit. It takes the CSR's TX byte and control byte and
//   returns the received byte for spi_in_reg. Single clock domain (wb_clk_i).
//
// Ports
//   wb_clk_i   : clock
//   wb_rst_i   : asynchronous reset, active high
//   tx_data_i  : byte to transmit, captured at the start edge
//   ctrl_i     : [0] go (rising edge starts), [1] cs_keep, [2] lsb_first
//   clk_div_i  : SCLK half-period minus 1 (D), captured at the start edge
//   abort_i    : synchronous abort, returns to idle and releases CS
//   rx_data_o  : last completed received byte
//   busy_o     : transfer in progress
//   done_o     : one-cycle completion pulse
//   spi_sel_o  : chip select, active low
//   spi_clk_o  : SCLK, idles low
//   spi_do_o   : MOSI
//   spi_di_i   : MISO
// -----------------------------------------------------------------------------
module spi_byte_engine #(
  parameter int DIV_W   = 8,
  parameter int CS_HOLD = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [7:0]       tx_data_i,
  input  logic [7:0]       ctrl_i,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic             abort_i,
  output logic [7:0]       rx_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             spi_sel_o,
  output logic             spi_clk_o,
  output logic             spi_do_o,
  input  logic             spi_di_i
);

  localparam int HOLD_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD
  } state_t;

  state_t state_q, state_nxt;

  logic             go_q;
  logic             keep_q;
  logic             lsb_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       tx_sr_q;
  logic [7:0]       rx_sr_q;

  logic start;
  logic phase_end;
  logic hold_end;
  logic last_bit;
  logic load;
  logic enter_high;
  logic enter_low;
  logic bit_adv;
  logic finish;
  logic [7:0] tx_next;

  // Upper control bits are reserved.
  logic ctrl_unused;
  assign ctrl_unused = ^ctrl_i[7:3];

  // Bit on the wire for a given shift-register content and order.
  function automatic logic wire_bit(input logic [7:0] b, input logic lsb);
    return lsb ? b[0] : b[7];
  endfunction

  // Advance the TX register so the next bit sits at the wire position.
  function automatic logic [7:0] shift_tx(input logic [7:0] b, input logic lsb);
    return lsb ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
  endfunction

  // Insert a sampled MISO bit so that the first bit ends in rx[7]
  // (MSB-first) or rx[0] (LSB-first) after eight samples.
  function automatic logic [7:0] shift_rx(input logic [7:0] b, input logic lsb,
                                          input logic bit_in);
    return lsb ? {bit_in, b[7:1]} : {b[6:0], bit_in};
  endfunction

  assign start     = ctrl_i[0] & ~go_q;
  assign phase_end = (cnt_q == div_q);
  assign hold_end  = (hold_cnt_q == HOLD_LAST);
  assign last_bit  = (bit_cnt_q == 3'd7);
  assign tx_next   = shift_tx(tx_sr_q, lsb_q);

  // CS stays asserted across back-to-back bytes while cs_keep holds it.
  assign spi_sel_o = ~(busy_o | keep_q);

  always_comb begin
    state_nxt  = state_q;
    load       = 1'b0;
    enter_high = 1'b0;
    enter_low  = 1'b0;
    bit_adv    = 1'b0;
    finish     = 1'b0;
    if (abort_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_SETUP;
            load      = 1'b1;
          end
        end
        S_SETUP: begin
          if (phase_end) begin
            state_nxt  = S_HIGH;
            enter_high = 1'b1;
          end
        end
        S_HIGH: begin
          if (phase_end) begin
            state_nxt = S_LOW;
            enter_low = 1'b1;
          end
        end
        S_LOW: begin
          if (phase_end) begin
            bit_adv = 1'b1;
            if (last_bit) begin
              state_nxt = S_HOLD;
            end else begin
              state_nxt  = S_HIGH;
              enter_high = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (hold_end) begin
            state_nxt = S_IDLE;
            finish    = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Control: FSM, phase counters, handshake and pin state.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      go_q       <= 1'b0;
      keep_q     <= 1'b0;
      cnt_q      <= '0;
      hold_cnt_q <= '0;
      bit_cnt_q  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      spi_clk_o  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      go_q    <= ctrl_i[0];
      done_o  <= finish;

      // Half-period counter restarts on every phase change.
      if ((state_nxt == state_q) &&
          ((state_q == S_SETUP) || (state_q == S_HIGH) || (state_q == S_LOW)))
        cnt_q <= cnt_q + DIV_W'(1);
      else
        cnt_q <= '0;

      if ((state_q == S_HOLD) && (state_nxt == S_HOLD))
        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
      else
        hold_cnt_q <= '0;

      if (load)
        bit_cnt_q <= '0;
      else if (bit_adv)
        bit_cnt_q <= bit_cnt_q + 3'd1;

      if (abort_i || finish)
        busy_o <= 1'b0;
      else if (load)
        busy_o <= 1'b1;

      if (abort_i || enter_low)
        spi_clk_o <= 1'b0;
      else if (enter_high)
        spi_clk_o <= 1'b1;

      // cs_keep is latched at completion; in idle it can only be cleared.
      if (abort_i)
        keep_q <= 1'b0;
      else if (finish)
        keep_q <= ctrl_i[1];
      else if (state_q == S_IDLE)
        keep_q <= keep_q & ctrl_i[1];
    end
  end

  // Datapath: shift registers, captured settings and received byte.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lsb_q     <= 1'b0;
      div_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_o <= '0;
      spi_do_o  <= 1'b0;
    end else begin
      if (load) begin
        lsb_q    <= ctrl_i[2];
        div_q    <= clk_div_i;
        tx_sr_q  <= tx_data_i;
        spi_do_o <= wire_bit(tx_data_i, ctrl_i[2]);
      end else if (enter_low && !last_bit) begin
        // The final bit is held through the last low phase.
        tx_sr_q  <= tx_next;
        spi_do_o <= wire_bit(tx_next, lsb_q);
      end

      if (enter_high)
        rx_sr_q <= shift_rx(rx_sr_q, lsb_q, spi_di_i);

      if (finish)
        rx_data_o <= rx_sr_q;
    end
  end

endmodule

// File: tb/tb_spi_byte_engine.sv
`timescale 1ns/1ps
module tb_spi_byte_engine;
  localparam int DIV_W   = 8;
  localparam int CS_HOLD = 2;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i = 1'b1;
  logic [7:0]       tx_data_i = '0;
  logic [7:0]       ctrl_i = '0;
  logic [DIV_W-1:0] clk_div_i = '0;
  logic             abort_i = 1'b0;
  logic [7:0]       rx_data_o;
  logic             busy_o, done_o, spi_sel_o, spi_clk_o, spi_do_o;
  logic             spi_di_i;

  // MISO source: 0 loopback, 1 random, 2 high only for the first sample.
  int   di_mode = 0;
  logic di_rand = 1'b0;
  logic di_first = 1'b0;
  assign spi_di_i = (di_mode == 0) ? spi_do_o : (di_mode == 1) ? di_rand : di_first;

  always #5 wb_clk_i = ~wb_clk_i;

  spi_byte_engine #(.DIV_W(DIV_W), .CS_HOLD(CS_HOLD)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .tx_data_i(tx_data_i),
    .ctrl_i   (ctrl_i),
    .clk_div_i(clk_div_i),
    .abort_i  (abort_i),
    .rx_data_o(rx_data_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .spi_sel_o(spi_sel_o),
    .spi_clk_o(spi_clk_o),
    .spi_do_o (spi_do_o),
    .spi_di_i (spi_di_i)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A transfer is described by its offset k from the start edge (k=1 is the
  // first busy cycle); pin values follow from k by arithmetic.
  logic       m_go_q = 0, m_keep = 0, m_active = 0, m_done = 0, m_lsb = 0, m_loop = 0;
  logic [7:0] m_rx = 0, m_tx = 0, m_acc = 0;
  int         m_k = 0, m_d = 0;

  initial forever begin
    @(posedge wb_clk_i or posedge wb_rst_i);
    if (wb_rst_i) begin
      m_go_q = 0; m_keep = 0; m_active = 0; m_done = 0; m_lsb = 0; m_loop = 0;
      m_rx = 0; m_tx = 0; m_acc = 0; m_k = 0; m_d = 0;
    end else begin
      logic st;
      int   q, per, n;
      st     = ctrl_i[0] && !m_go_q;
      m_go_q = ctrl_i[0];
      m_done = 0;
      if (abort_i) begin
        m_active = 0;
        m_keep   = 0;
      end else if (m_active) begin
        per = 2 * (m_d + 1);
        q   = m_k - (m_d + 1);
        if (q >= 0 && (q % per) == 0 && (q / per) < 8) begin
          n = q / per;
          m_acc[m_lsb ? n : 7 - n] = spi_di_i;
        end
        if (m_k == 17 * (m_d + 1) + CS_HOLD) begin
          m_active = 0;
          m_done   = 1;
          m_keep   = ctrl_i[1];
          m_rx     = m_loop ? m_tx : m_acc;
        end else begin
          m_k++;
        end
      end else begin
        m_keep = m_keep & ctrl_i[1];
        if (st) begin
          m_active = 1;
          m_k      = 1;
          m_d      = int'(clk_div_i);
          m_tx     = tx_data_i;
          m_lsb    = ctrl_i[2];
          m_loop   = (di_mode == 0);
          m_acc    = 0;
        end
      end
    end
  end

  function automatic logic exp_clk(input int k, input int d);
    int p;
    p = k - 1 - (d + 1);
    return (p >= 0) && (p < 16 * (d + 1)) && (((p / (d + 1)) % 2) == 0);
  endfunction

  function automatic logic exp_do(input int k, input int d, input logic [7:0] tx, input logic lsb);
    int j;
    j = (k - 1) / (2 * (d + 1));
    if (j > 7) j = 7;
    return lsb ? tx[j] : tx[7 - j];
  endfunction

  // Compare DUT against the model every cycle, away from the active edge.
  initial forever begin
    @(negedge wb_clk_i);
    check("busy", busy_o, m_active);
    check("done", done_o, m_done);
    check("sel", spi_sel_o, !(m_active || m_keep));
    check("sclk", spi_clk_o, m_active ? exp_clk(m_k, m_d) : 1'b0);
    check("rx", rx_data_o, m_rx);
    if (m_active) check("mosi", spi_do_o, exp_do(m_k, m_d, m_tx, m_lsb));
  end

  // ---------------- directed transfer with literal expectations ----------------
  task automatic xfer(input logic [7:0] tx, input logic [7:0] ctrl, input int d, input int mode,
                      input int exp_off, input logic [7:0] exp_mosi,
                      input logic chk_rx, input logic [7:0] exp_rx, input string tag);
    int t0, off, pulses, hi, bsy;
    logic [7:0] mosi;
    logic prev_clk, seen;
    @(negedge wb_clk_i);
    di_mode   = mode;
    di_first  = 1'b1;
    tx_data_i = tx;
    clk_div_i = DIV_W'(d);
    ctrl_i    = ctrl;
    t0 = cyc; off = -1; pulses = 0; hi = 0; bsy = 0; mosi = 0; prev_clk = 0; seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge wb_clk_i);
      if (spi_clk_o && !prev_clk) begin
        pulses++;
        mosi = {mosi[6:0], spi_do_o};
        di_first = 1'b0;
      end
      prev_clk = spi_clk_o;
      if (spi_clk_o) hi++;
      if (busy_o) bsy++;
      if (done_o) begin
        seen = 1;
        off  = cyc - t0;
      end
    end
    check({tag, " done_seen"}, seen, 1);
    check({tag, " done_offset"}, off, exp_off);
    check({tag, " pulses"}, pulses, 8);
    check({tag, " mosi_seq"}, mosi, exp_mosi);
    check({tag, " sclk_high_cycles"}, hi, 8 * (d + 1));
    check({tag, " busy_cycles"}, bsy, exp_off - 1);
    if (chk_rx) check({tag, " rx"}, rx_data_o, exp_rx);
    ctrl_i[0] = 1'b0;
  endtask

  initial begin
    int cnt, pulses;
    logic prev_clk, hit;

    // Reset state
    @(negedge wb_clk_i);
    check("rst busy", busy_o, 0);
    check("rst done", done_o, 0);
    check("rst sel", spi_sel_o, 1);
    check("rst sclk", spi_clk_o, 0);
    check("rst mosi", spi_do_o, 0);
    check("rst rx", rx_data_o, 0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    // D=0, loopback, MSB first
    xfer(8'hA5, 8'h01, 0, 0, 20, 8'hA5, 1, 8'hA5, "t1");
    // LSB first, only the first sampled bit is 1
    xfer(8'h01, 8'h05, 0, 2, 20, 8'h80, 1, 8'h01, "t2");
    // D=3, random MISO
    xfer(8'h3C, 8'h01, 3, 1, 71, 8'h3C, 0, 8'h00, "t3");

    // cs_keep across two bytes, then release
    xfer(8'h96, 8'h03, 0, 0, 20, 8'h96, 1, 8'h96, "t4a");
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      check("keep gap sel", spi_sel_o, 0);
    end
    xfer(8'h69, 8'h03, 1, 0, 37, 8'h69, 1, 8'h69, "t4b");
    @(negedge wb_clk_i);
    check("keep held sel", spi_sel_o, 0);
    ctrl_i = 8'h00;
    @(negedge wb_clk_i);
    check("keep release sel", spi_sel_o, 1);

    // Second go edge mid-transfer is dropped
    @(negedge wb_clk_i);
    di_mode = 0; tx_data_i = 8'h5A; clk_div_i = 8'd1; ctrl_i = 8'h01;
    repeat (6) @(negedge wb_clk_i);
    ctrl_i = 8'h00;
    repeat (2) @(negedge wb_clk_i);
    ctrl_i = 8'h01;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge wb_clk_i);
      if (done_o) cnt++;
    end
    check("rego done_count", cnt, 1);
    check("rego rx", rx_data_o, 8'h5A);
    ctrl_i = 8'h00;
    @(negedge wb_clk_i);

    // Abort after the 4th SCLK pulse
    @(negedge wb_clk_i);
    tx_data_i = 8'hC3; clk_div_i = 8'd1; ctrl_i = 8'h01;
    pulses = 0; prev_clk = 0; hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge wb_clk_i);
      if (spi_clk_o && !prev_clk) pulses++;
      prev_clk = spi_clk_o;
      if (pulses == 4 && !spi_clk_o) hit = 1;
    end
    check("abort reached_4th_pulse", hit, 1);
    abort_i = 1'b1;
    @(negedge wb_clk_i);
    abort_i = 1'b0;
    check("abort sel", spi_sel_o, 1);
    check("abort sclk", spi_clk_o, 0);
    check("abort busy", busy_o, 0);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge wb_clk_i);
      if (done_o) cnt++;
    end
    check("abort no_done", cnt, 0);
    check("abort rx_kept", rx_data_o, 8'h5A);
    ctrl_i = 8'h00;
    @(negedge wb_clk_i);

    // Asynchronous reset during a high phase
    @(negedge wb_clk_i);
    di_mode = 1; di_rand = 1'b1; tx_data_i = 8'hFF; clk_div_i = 8'd2; ctrl_i = 8'h01;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge wb_clk_i);
      if (spi_clk_o) hit = 1;
    end
    check("arst reached_high", hit, 1);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check("arst busy", busy_o, 0);
    check("arst sclk", spi_clk_o, 0);
    check("arst sel", spi_sel_o, 1);
    check("arst done", done_o, 0);
    check("arst mosi", spi_do_o, 0);
    check("arst rx", rx_data_o, 0);
    @(negedge wb_clk_i);
    ctrl_i = 8'h00;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // Maximum divider: counters must not wrap early
    xfer(8'hB2, 8'h01, 255, 1, 17 * 256 + CS_HOLD + 1, 8'hB2, 0, 8'h00, "dmax");

    // Randomized traffic, checked by the model every cycle
    di_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge wb_clk_i);
      di_rand   = 1'($urandom_range(0, 1));
      tx_data_i = 8'($urandom);
      clk_div_i = DIV_W'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) ctrl_i = 8'($urandom);
      abort_i = ($urandom_range(0, 199) == 0);
    end
    @(negedge wb_clk_i);
    abort_i = 1'b0;
    ctrl_i  = 8'h00;
    repeat (5) @(negedge wb_clk_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
